fu_branch_unit: RTL and testbench

- Parametrised branch/jump functional unit. Sits between the branch reservation station/PRF read and the CDB/ROB writeback.
- Resolves all RV32I conditional branches, plus JAL and JALR, against a per-instruction prediction.
- Registers each result into an OUT_DEPTH-entry output FIFO with valid/ready toward the CDB.
- Squashes in-flight entries younger than a ROB flush tag, using head-relative age.

---
 rtl/fu_branch_unit_if.sv | 46 ++++
 rtl/fu_branch_unit.sv | 178 +++++++++++++++++
 tb/tb_fu_branch_unit.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_branch_unit_if.sv
// Issue and writeback bundle for the branch functional unit.
interface fu_branch_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned PREG_W = 7
);
    logic              issue_valid;
    logic              issue_ready;
    logic [6:0]        issue_opcode;
    logic [2:0]        issue_func3;
    logic [XLEN-1:0]   issue_pc;
    logic [XLEN-1:0]   issue_imm;
    logic [XLEN-1:0]   issue_rs1_data;
    logic [XLEN-1:0]   issue_rs2_data;
    logic [PREG_W-1:0] issue_pd;
    logic [TAG_W-1:0]  issue_rob_tag;
    logic              issue_pred_taken;
    logic [XLEN-1:0]   issue_pred_target;

    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_rob_tag;
    logic [PREG_W-1:0] out_pd;
    logic              out_wen;
    logic [XLEN-1:0]   out_data;
    logic              out_mispredict;
    logic [XLEN-1:0]   out_redirect_pc;

    // Reservation station / CDB side
    modport master (
        output issue_valid, issue_opcode, issue_func3, issue_pc, issue_imm,
               issue_rs1_data, issue_rs2_data, issue_pd, issue_rob_tag,
               issue_pred_taken, issue_pred_target, out_ready,
        input  issue_ready, out_valid, out_rob_tag, out_pd, out_wen,
               out_data, out_mispredict, out_redirect_pc
    );

    // Branch unit side
    modport slave (
        input  issue_valid, issue_opcode, issue_func3, issue_pc, issue_imm,
               issue_rs1_data, issue_rs2_data, issue_pd, issue_rob_tag,
               issue_pred_taken, issue_pred_target, out_ready,
        output issue_ready, out_valid, out_rob_tag, out_pd, out_wen,
               out_data, out_mispredict, out_redirect_pc
    );
endinterface

// File: rtl/fu_branch_unit.sv
// Branch/jump resolution unit: resolves RV32I branches, JAL and JALR against
// the frontend prediction and buffers results in a small flushable FIFO.
module fu_branch_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned TAG_W     = $clog2(ROB_DEPTH),
    parameter int unsigned PREG_W    = 7,
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    fu_branch_unit_if.slave  bus,
    input  logic [TAG_W-1:0] rob_head,
    input  logic             flush_valid,
    input  logic [TAG_W-1:0] flush_tag
);
    localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  rob_tag;
        logic [PREG_W-1:0] pd;
        logic              wen;
        logic [XLEN-1:0]   data;
        logic              mispredict;
        logic [XLEN-1:0]   redirect_pc;
    } slot_t;

    slot_t             slots [OUT_DEPTH];
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count;

    logic              taken_c;
    logic              is_cbr_c;
    logic              is_jump_c;
    logic [XLEN-1:0]   pc_plus4_c;
    logic [XLEN-1:0]   target_c;
    logic              mispredict_c;
    logic [XLEN-1:0]   redirect_c;
    logic [XLEN-1:0]   link_c;
    logic              accept_c;
    logic              advance_c;
    logic              head_killed_c;
    logic              out_valid_c;
    logic              issue_killed_c;
    slot_t             head_slot_c;

    // Head-relative age; the ROB wraps at ROB_DEPTH.
    function automatic logic [TAG_W-1:0] age_of(input logic [TAG_W-1:0] tag,
                                                 input logic [TAG_W-1:0] head);
        return (tag - head) & TAG_W'(ROB_DEPTH - 1);
    endfunction

    function automatic logic younger(input logic [TAG_W-1:0] tag,
                                     input logic [TAG_W-1:0] head,
                                     input logic [TAG_W-1:0] ftag);
        return age_of(tag, head) > age_of(ftag, head);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Decode, compare and prediction check for the instruction being issued.
    always_comb begin
        taken_c      = 1'b0;
        is_cbr_c     = 1'b0;
        is_jump_c    = 1'b0;
        pc_plus4_c   = bus.issue_pc + XLEN'(4);
        target_c     = bus.issue_pc + bus.issue_imm;
        mispredict_c = 1'b0;
        redirect_c   = '0;
        link_c       = '0;

        case (bus.issue_opcode)
            OPC_BRANCH: begin
                is_cbr_c = 1'b1;
                case (bus.issue_func3)
                    3'b000:  taken_c = (bus.issue_rs1_data == bus.issue_rs2_data);
                    3'b001:  taken_c = (bus.issue_rs1_data != bus.issue_rs2_data);
                    3'b100:  taken_c = ($signed(bus.issue_rs1_data) <  $signed(bus.issue_rs2_data));
                    3'b101:  taken_c = ($signed(bus.issue_rs1_data) >= $signed(bus.issue_rs2_data));
                    3'b110:  taken_c = (bus.issue_rs1_data <  bus.issue_rs2_data);
                    3'b111:  taken_c = (bus.issue_rs1_data >= bus.issue_rs2_data);
                    default: taken_c = 1'b0;
                endcase
            end
            OPC_JAL: begin
                taken_c   = 1'b1;
                is_jump_c = 1'b1;
            end
            OPC_JALR: begin
                if (bus.issue_func3 == 3'b000) begin
                    taken_c   = 1'b1;
                    is_jump_c = 1'b1;
                    target_c  = (bus.issue_rs1_data + bus.issue_imm) & ~XLEN'(1);
                end
            end
            default: ;
        endcase

        if (is_cbr_c) begin
            mispredict_c = (taken_c != bus.issue_pred_taken) ||
                           (taken_c && (target_c != bus.issue_pred_target));
        end else if (is_jump_c) begin
            mispredict_c = !bus.issue_pred_taken || (target_c != bus.issue_pred_target);
        end else begin
            mispredict_c = bus.issue_pred_taken;
        end

        if (mispredict_c) begin
            redirect_c = taken_c ? target_c : pc_plus4_c;
        end
        if (is_jump_c) begin
            link_c = pc_plus4_c;
        end
    end

    // FIFO handshake; a killed head drains one slot per cycle on its own.
    always_comb begin
        head_slot_c    = slots[head_ptr];
        head_killed_c  = flush_valid && younger(head_slot_c.rob_tag, rob_head, flush_tag);
        out_valid_c    = (count != '0) && head_slot_c.valid && !head_killed_c;
        advance_c      = (count != '0) &&
                         (!head_slot_c.valid || (out_valid_c && bus.out_ready));
        accept_c       = bus.issue_valid && bus.issue_ready;
        issue_killed_c = flush_valid && younger(bus.issue_rob_tag, rob_head, flush_tag);
    end

    // FIFO storage, pointers and flush invalidation.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < int'(OUT_DEPTH); i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (flush_valid) begin
                for (int i = 0; i < int'(OUT_DEPTH); i++) begin
                    if (younger(slots[i].rob_tag, rob_head, flush_tag)) begin
                        slots[i].valid <= 1'b0;
                    end
                end
            end
            if (accept_c) begin
                slots[tail_ptr] <= '{valid:       !issue_killed_c,
                                     rob_tag:     bus.issue_rob_tag,
                                     pd:          bus.issue_pd,
                                     wen:         is_jump_c,
                                     data:        link_c,
                                     mispredict:  mispredict_c,
                                     redirect_pc: redirect_c};
                tail_ptr <= ptr_inc(tail_ptr);
            end
            if (advance_c) begin
                head_ptr <= ptr_inc(head_ptr);
            end
            count <= count + CNT_W'(accept_c) - CNT_W'(advance_c);
        end
    end

    assign bus.issue_ready     = (count < CNT_W'(OUT_DEPTH));
    assign bus.out_valid       = out_valid_c;
    assign bus.out_rob_tag     = head_slot_c.rob_tag;
    assign bus.out_pd          = head_slot_c.pd;
    assign bus.out_wen         = head_slot_c.wen;
    assign bus.out_data        = head_slot_c.data;
    assign bus.out_mispredict  = head_slot_c.mispredict;
    assign bus.out_redirect_pc = head_slot_c.redirect_pc;
endmodule

// File: tb/tb_fu_branch_unit.sv
// Directed bench for fu_branch_unit: a 2-deep instance for datapath and
// backpressure, a 4-deep instance for flush scenarios.
module tb_fu_branch_unit;
    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_func3;
    logic [31:0] issue_pc, issue_imm, issue_rs1_data, issue_rs2_data, issue_pred_target;
    logic [6:0]  issue_pd;
    logic [3:0]  issue_rob_tag;
    logic        issue_pred_taken;
    logic        out_ready;
    logic [3:0]  rob_head;
    logic        flush_valid;
    logic [3:0]  flush_tag;

    int checks;
    int failures;

    fu_branch_unit_if #(.XLEN(32), .TAG_W(4), .PREG_W(7)) bus2 ();
    fu_branch_unit_if #(.XLEN(32), .TAG_W(4), .PREG_W(7)) bus4 ();

    assign bus2.issue_valid = issue_valid;             assign bus4.issue_valid = issue_valid;
    assign bus2.issue_opcode = issue_opcode;           assign bus4.issue_opcode = issue_opcode;
    assign bus2.issue_func3 = issue_func3;             assign bus4.issue_func3 = issue_func3;
    assign bus2.issue_pc = issue_pc;                   assign bus4.issue_pc = issue_pc;
    assign bus2.issue_imm = issue_imm;                 assign bus4.issue_imm = issue_imm;
    assign bus2.issue_rs1_data = issue_rs1_data;       assign bus4.issue_rs1_data = issue_rs1_data;
    assign bus2.issue_rs2_data = issue_rs2_data;       assign bus4.issue_rs2_data = issue_rs2_data;
    assign bus2.issue_pd = issue_pd;                   assign bus4.issue_pd = issue_pd;
    assign bus2.issue_rob_tag = issue_rob_tag;         assign bus4.issue_rob_tag = issue_rob_tag;
    assign bus2.issue_pred_taken = issue_pred_taken;   assign bus4.issue_pred_taken = issue_pred_taken;
    assign bus2.issue_pred_target = issue_pred_target; assign bus4.issue_pred_target = issue_pred_target;
    assign bus2.out_ready = out_ready;                  assign bus4.out_ready = out_ready;

    fu_branch_unit #(.XLEN(32), .ROB_DEPTH(16), .TAG_W(4), .PREG_W(7), .OUT_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .rob_head(rob_head), .flush_valid(flush_valid), .flush_tag(flush_tag)
    );

    fu_branch_unit #(.XLEN(32), .ROB_DEPTH(16), .TAG_W(4), .PREG_W(7), .OUT_DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4),
        .rob_head(rob_head), .flush_valid(flush_valid), .flush_tag(flush_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_issue(input logic [6:0] opc, input logic [2:0] f3,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [6:0] pd, input logic [3:0] tag,
                               input logic pt, input logic [31:0] ptgt);
        issue_opcode = opc;  issue_func3 = f3;  issue_pc = pc;  issue_imm = imm;
        issue_rs1_data = rs1;  issue_rs2_data = rs2;  issue_pd = pd;
        issue_rob_tag = tag;  issue_pred_taken = pt;  issue_pred_target = ptgt;
        issue_valid = 1'b1;
    endtask

    // One accept edge, then park at the following negedge with the result at head.
    task automatic accept_and_settle();
        @(posedge clk); #1;
        issue_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_head();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        issue_valid = 1'b0; out_ready = 1'b0; flush_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus2.out_valid); end
        checks++; if (bus2.issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%0b exp=1", bus2.issue_ready); end
        checks++; if (bus2.out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus2.out_data); end
        checks++; if (bus4.issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready4 got=%0b exp=1", bus4.issue_ready); end
    endtask

    task automatic test_cond_branch();
        // BNE equal operands: not taken, correctly predicted
        drive_issue(7'b1100011, 3'b001, 32'h100, 32'h20, 32'd5, 32'd5, 7'd0, 4'd3, 1'b0, 32'h0);
        accept_and_settle();
        checks++; if (bus2.out_valid !== 1'b1) begin failures++; $display("FAIL bne_valid got=%0b exp=1", bus2.out_valid); end
        checks++; if (bus2.out_rob_tag !== 4'd3) begin failures++; $display("FAIL bne_tag got=%0d exp=3", bus2.out_rob_tag); end
        checks++; if (bus2.out_mispredict !== 1'b0) begin failures++; $display("FAIL bne_misp got=%0b exp=0", bus2.out_mispredict); end
        checks++; if (bus2.out_wen !== 1'b0) begin failures++; $display("FAIL bne_wen got=%0b exp=0", bus2.out_wen); end
        checks++; if (bus2.out_redirect_pc !== 32'h0) begin failures++; $display("FAIL bne_redirect got=%h exp=0", bus2.out_redirect_pc); end
        pop_head();
        checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL bne_drained got=%0b exp=0", bus2.out_valid); end

        // BLT -1 < 1 signed: taken, predicted not taken
        drive_issue(7'b1100011, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 7'd0, 4'd4, 1'b0, 32'h0);
        accept_and_settle();
        checks++; if (bus2.out_mispredict !== 1'b1) begin failures++; $display("FAIL blt_misp got=%0b exp=1", bus2.out_mispredict); end
        checks++; if (bus2.out_redirect_pc !== 32'h240) begin failures++; $display("FAIL blt_redirect got=%h exp=240", bus2.out_redirect_pc); end
        pop_head();

        // BLTU same operands: 0xFFFFFFFF < 1 unsigned is false
        drive_issue(7'b1100011, 3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 7'd0, 4'd5, 1'b0, 32'h0);
        accept_and_settle();
        checks++; if (bus2.out_mispredict !== 1'b0) begin failures++; $display("FAIL bltu_misp got=%0b exp=0", bus2.out_mispredict); end
        checks++; if (bus2.out_redirect_pc !== 32'h0) begin failures++; $display("FAIL bltu_redirect got=%h exp=0", bus2.out_redirect_pc); end
        pop_head();

        // BGE not taken but predicted taken: redirect to pc+4
        drive_issue(7'b1100011, 3'b101, 32'h400, 32'h80, 32'd3, 32'd7, 7'd0, 4'd6, 1'b1, 32'h480);
        accept_and_settle();
        checks++; if (bus2.out_redirect_pc !== 32'h404) begin failures++; $display("FAIL bge_redirect got=%h exp=404", bus2.out_redirect_pc); end
        pop_head();

        // Reserved func3 010: never taken
        drive_issue(7'b1100011, 3'b010, 32'h500, 32'h10, 32'd1, 32'd1, 7'd0, 4'd7, 1'b0, 32'h0);
        accept_and_settle();
        checks++; if (bus2.out_mispredict !== 1'b0) begin failures++; $display("FAIL f3_010_misp got=%0b exp=0", bus2.out_mispredict); end
        pop_head();
    endtask

    task automatic test_jumps();
        // JALR: (0x1003 + 4) & ~1 = 0x1006, prediction correct
        drive_issue(7'b1100111, 3'b000, 32'h300, 32'd4, 32'h1003, 32'h0, 7'd9, 4'd8, 1'b1, 32'h1006);
        accept_and_settle();
        checks++; if (bus2.out_wen !== 1'b1) begin failures++; $display("FAIL jalr_wen got=%0b exp=1", bus2.out_wen); end
        checks++; if (bus2.out_pd !== 7'd9) begin failures++; $display("FAIL jalr_pd got=%0d exp=9", bus2.out_pd); end
        checks++; if (bus2.out_data !== 32'h304) begin failures++; $display("FAIL jalr_data got=%h exp=304", bus2.out_data); end
        checks++; if (bus2.out_mispredict !== 1'b0) begin failures++; $display("FAIL jalr_misp got=%0b exp=0", bus2.out_mispredict); end
        pop_head();

        // JALR with wrong predicted target
        drive_issue(7'b1100111, 3'b000, 32'h300, 32'd4, 32'h1003, 32'h0, 7'd9, 4'd9, 1'b1, 32'h1000);
        accept_and_settle();
        checks++; if (bus2.out_mispredict !== 1'b1) begin failures++; $display("FAIL jalr2_misp got=%0b exp=1", bus2.out_mispredict); end
        checks++; if (bus2.out_redirect_pc !== 32'h1006) begin failures++; $display("FAIL jalr2_redirect got=%h exp=1006", bus2.out_redirect_pc); end
        pop_head();

        // JAL at top of address space: target and link wrap modulo 2^32
        drive_issue(7'b1101111, 3'b000, 32'hFFFF_FFFC, 32'd8, 32'h0, 32'h0, 7'd2, 4'd10, 1'b1, 32'h4);
        accept_and_settle();
        checks++; if (bus2.out_data !== 32'h0) begin failures++; $display("FAIL jal_wrap_data got=%h exp=0", bus2.out_data); end
        checks++; if (bus2.out_mispredict !== 1'b0) begin failures++; $display("FAIL jal_wrap_misp got=%0b exp=0", bus2.out_mispredict); end
        checks++; if (bus2.out_wen !== 1'b1) begin failures++; $display("FAIL jal_wrap_wen got=%0b exp=1", bus2.out_wen); end
        pop_head();

        // Non-branch predicted taken: mispredict, redirect to pc+4, no write
        drive_issue(7'b0110011, 3'b000, 32'h600, 32'h0, 32'h0, 32'h0, 7'd4, 4'd11, 1'b1, 32'h700);
        accept_and_settle();
        checks++; if (bus2.out_mispredict !== 1'b1) begin failures++; $display("FAIL alu_misp got=%0b exp=1", bus2.out_mispredict); end
        checks++; if (bus2.out_redirect_pc !== 32'h604) begin failures++; $display("FAIL alu_redirect got=%h exp=604", bus2.out_redirect_pc); end
        checks++; if (bus2.out_wen !== 1'b0) begin failures++; $display("FAIL alu_wen got=%0b exp=0", bus2.out_wen); end
        pop_head();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive_issue(7'b1100011, 3'b000, 32'h10, 32'h8, 32'd1, 32'd2, 7'd0, 4'd1, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive_issue(7'b1100011, 3'b000, 32'h14, 32'h8, 32'd1, 32'd2, 7'd0, 4'd2, 1'b0, 32'h0);
        accept_and_settle();
        checks++; if (bus2.issue_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", bus2.issue_ready); end
        checks++; if (bus2.out_rob_tag !== 4'd1) begin failures++; $display("FAIL bp_first_tag got=%0d exp=1", bus2.out_rob_tag); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus2.out_valid !== 1'b1 || bus2.out_rob_tag !== 4'd2) begin failures++; $display("FAIL bp_second got=%0b/%0d exp=1/2", bus2.out_valid, bus2.out_rob_tag); end
        @(negedge clk);
        checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty_valid got=%0b exp=0", bus2.out_valid); end
        checks++; if (bus2.issue_ready !== 1'b1) begin failures++; $display("FAIL bp_empty_ready got=%0b exp=1", bus2.issue_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [3:0] seen [4];
        int n;
        apply_reset();
        rob_head = 4'd14;
        drive_issue(7'b0110011, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 7'd1, 4'd15, 1'b0, 32'h0);
        @(posedge clk); #1;
        issue_rob_tag = 4'd0;
        @(posedge clk); #1;
        issue_rob_tag = 4'd1;
        @(posedge clk); #1;
        issue_rob_tag = 4'd2;
        flush_valid = 1'b1;
        flush_tag = 4'd0;
        @(negedge clk);
        checks++; if (bus4.out_valid !== 1'b1 || bus4.out_rob_tag !== 4'd15) begin failures++; $display("FAIL flush_head_kept got=%0b/%0d exp=1/15", bus4.out_valid, bus4.out_rob_tag); end
        @(posedge clk); #1;
        issue_valid = 1'b0;
        flush_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus4.issue_ready !== 1'b0) begin failures++; $display("FAIL flush_slots_held got=%0b exp=0", bus4.issue_ready); end
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus4.out_valid === 1'b1) begin
                if (n < 4) seen[n] = bus4.out_rob_tag;
                n++;
            end
            @(negedge clk);
        end
        checks++; if (n !== 2) begin failures++; $display("FAIL flush_emerged_count got=%0d exp=2", n); end
        checks++; if (n >= 2 && (seen[0] !== 4'd15 || seen[1] !== 4'd0)) begin failures++; $display("FAIL flush_order got=%0d,%0d exp=15,0", seen[0], seen[1]); end
        checks++; if (bus4.issue_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin failures++; $display("FAIL flush_drained got=%0b/%0b exp=1/0", bus4.issue_ready, bus4.out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_head_kill();
        int n;
        apply_reset();
        rob_head = 4'd0;
        out_ready = 1'b1;
        drive_issue(7'b1101111, 3'b000, 32'h40, 32'h8, 32'h0, 32'h0, 7'd3, 4'd5, 1'b1, 32'h48);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        flush_valid = 1'b1;
        flush_tag = 4'd3;
        @(negedge clk);
        checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("FAIL headkill_gate got=%0b exp=0", bus4.out_valid); end
        @(posedge clk); #1;
        flush_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus4.out_valid === 1'b1) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL headkill_leak got=%0d exp=0", n); end
        checks++; if (bus4.issue_ready !== 1'b1) begin failures++; $display("FAIL headkill_ready got=%0b exp=1", bus4.issue_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int n;
        out_ready = 1'b0;
        drive_issue(7'b1101111, 3'b000, 32'h800, 32'h10, 32'h0, 32'h0, 7'd3, 4'd6, 1'b0, 32'h0);
        @(posedge clk); #1;
        issue_rob_tag = 4'd7;
        accept_and_settle();
        checks++; if (bus2.out_valid !== 1'b1 || bus2.issue_ready !== 1'b0) begin failures++; $display("FAIL rstmid_prefill got=%0b/%0b exp=1/0", bus2.out_valid, bus2.issue_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", bus2.out_valid); end
        checks++; if (bus2.issue_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", bus2.issue_ready); end
        checks++; if ({bus2.out_rob_tag, bus2.out_pd, bus2.out_wen, bus2.out_mispredict} !== 13'h0) begin failures++; $display("FAIL rstmid_fields got=%0d/%0d/%0b/%0b exp=0", bus2.out_rob_tag, bus2.out_pd, bus2.out_wen, bus2.out_mispredict); end
        checks++; if (bus2.out_data !== 32'h0 || bus2.out_redirect_pc !== 32'h0) begin failures++; $display("FAIL rstmid_data got=%h/%h exp=0", bus2.out_data, bus2.out_redirect_pc); end
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus2.out_valid === 1'b1) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL rstmid_ghost got=%0d exp=0", n); end
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        issue_valid = 1'b0; issue_opcode = '0; issue_func3 = '0; issue_pc = '0;
        issue_imm = '0; issue_rs1_data = '0; issue_rs2_data = '0; issue_pd = '0;
        issue_rob_tag = '0; issue_pred_taken = 1'b0; issue_pred_target = '0;
        out_ready = 1'b0; rob_head = '0; flush_valid = 1'b0; flush_tag = '0;

        test_reset();
        test_cond_branch();
        test_jumps();
        test_back_to_back();
        test_flush();
        test_head_kill();
        test_reset_midstream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
